// File: rtl/parking_pkg.sv
// Shared gate-state encoding and default sizing for the parking gate controller.
package parking_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_state_e;

  localparam int DEF_CAPACITY    = 10;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_OPEN_CYCLES = 4;

endpackage

// File: rtl/gate_fsm.sv
// One gate: sensor rising-edge detect, IDLE/OPEN FSM with hold timer, grant (same cycle) and reject pulse.
// Gate opens / reject pulses one cycle after the edge; edges while OPEN are dropped, nothing is queued.
module gate_fsm
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sensor,
  input  logic i_allow,
  output logic o_grant,
  output logic o_open,
  output logic o_reject
);

  localparam int TW = $clog2(OPEN_CYCLES + 1);

  gate_state_e   r_state;
  gate_state_e   w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_sensor_q;
  logic          r_reject;
  logic          w_reject_nxt;
  logic          w_edge;

  // Edge register resets to 0 so a sensor held high through reset counts as an edge.
  assign w_edge = i_sensor & ~r_sensor_q;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_reject_nxt = 1'b0;
    o_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          if (i_allow) begin
            o_grant     = 1'b1;
            w_state_nxt = OPEN;
            w_timer_nxt = TW'(OPEN_CYCLES);
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      OPEN: begin
        if (r_timer <= TW'(1)) begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_sensor_q <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_sensor_q <= i_sensor;
      r_reject   <= w_reject_nxt;
    end
  end

  assign o_open   = (r_state == OPEN);
  assign o_reject = r_reject;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot entry/exit gate controller with bounded occupancy counter and full/empty flags.
// Count and flags update one cycle after a sensor edge; no backpressure, refused requests pulse *_reject.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ent,
  input  logic             ext,
  output logic             ent_open,
  output logic             ext_open,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ent_reject,
  output logic             ext_reject
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_ent_allow;
  logic             w_ext_allow;
  logic             w_ent_grant;
  logic             w_ext_grant;

  // Decisions use the registered count only, so a same-cycle exit cannot admit into a full lot.
  assign w_ent_allow = (r_count < CNT_W'(CAPACITY));
  assign w_ext_allow = (r_count != '0);

  gate_fsm #(.OPEN_CYCLES(OPEN_CYCLES)) u_ent_gate (
    .i_clk    (clk),
    .i_rst_n  (clr),
    .i_sensor (ent),
    .i_allow  (w_ent_allow),
    .o_grant  (w_ent_grant),
    .o_open   (ent_open),
    .o_reject (ent_reject)
  );

  gate_fsm #(.OPEN_CYCLES(OPEN_CYCLES)) u_ext_gate (
    .i_clk    (clk),
    .i_rst_n  (clr),
    .i_sensor (ext),
    .i_allow  (w_ext_allow),
    .o_grant  (w_ext_grant),
    .o_open   (ext_open),
    .o_reject (ext_reject)
  );

  always_comb begin
    w_count_nxt = r_count;
    case ({w_ent_grant, w_ext_grant})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(CAPACITY));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_parking_gate_ctrl;

  logic       clk;
  logic       clr;
  logic       ent;
  logic       ext;
  logic       ent_open;
  logic       ext_open;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       ent_reject;
  logic       ext_reject;

  parking_gate_ctrl #(.CAPACITY(10), .CNT_W(4), .OPEN_CYCLES(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .ent        (ent),
    .ext        (ext),
    .ent_open   (ent_open),
    .ext_open   (ext_open),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ent_reject (ent_reject),
    .ext_reject (ext_reject)
  );

  typedef struct {
    string      tag;
    int         cyc;
    logic [9:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected value layout: {ent_open, ext_open, ent_reject, ext_reject, full, empty, count[3:0]}
  function automatic void expect_at(string tag, int off, bit eo, bit xo, bit er, bit xr,
                                    bit f, bit e, int cnt);
    exp_t x;
    logic [3:0] c;
    c     = cnt[3:0];
    x.tag = tag;
    x.cyc = cyc + off;
    x.val = {eo, xo, er, xr, f, e, c};
    sb_q.push_back(x);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [9:0] act;
    act = {ent_open, ext_open, ent_reject, ext_reject, full, empty, count};
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        n_checks++;
        if (sb_q[i].cyc < cyc) begin
          n_err++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d), required=%b",
                   sb_q[i].tag, sb_q[i].cyc, cyc, sb_q[i].val);
        end else if (act !== sb_q[i].val) begin
          n_err++;
          $display("FAIL %s @cyc %0d: actual eo,xo,er,xr,f,e,cnt=%b required=%b",
                   sb_q[i].tag, cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  initial begin
    clr = 1'b0;
    ent = 1'b0;
    ext = 1'b0;
    tick(2);
    expect_at("reset", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(1);
    clr = 1'b1;
    tick(1);

    // exit at empty lot is refused
    expect_at("ext_rej", 1, 0, 0, 0, 1, 0, 1, 0);
    expect_at("ext_rej_end", 2, 0, 0, 0, 0, 0, 1, 0);
    ext = 1'b1;
    tick(1);
    ext = 1'b0;
    tick(2);

    // single entry; a second edge during OPEN is dropped
    expect_at("ent_before", 0, 0, 0, 0, 0, 0, 1, 0);
    expect_at("ent_open1", 1, 1, 0, 0, 0, 0, 0, 1);
    expect_at("ent_ignored", 3, 1, 0, 0, 0, 0, 0, 1);
    expect_at("ent_open4", 4, 1, 0, 0, 0, 0, 0, 1);
    expect_at("ent_closed", 5, 0, 0, 0, 0, 0, 0, 1);
    ent = 1'b1;
    tick(1);
    ent = 1'b0;
    tick(1);
    ent = 1'b1;
    tick(1);
    ent = 1'b0;
    tick(2);

    // fill to capacity, each edge in the first IDLE cycle after the previous gate closed
    for (int k = 2; k <= 10; k++) begin
      expect_at("fill", 1, 1, 0, 0, 0, (k == 10), 0, k);
      ent = 1'b1;
      tick(1);
      ent = 1'b0;
      tick(4);
    end

    // 11th car refused
    expect_at("full_rej", 1, 0, 0, 1, 0, 1, 0, 10);
    expect_at("full_rej_end", 2, 0, 0, 0, 0, 1, 0, 10);
    ent = 1'b1;
    tick(1);
    ent = 1'b0;
    tick(2);

    // full lot: simultaneous entry is still refused, exit proceeds
    expect_at("full_both", 1, 0, 1, 1, 0, 0, 0, 9);
    expect_at("full_both2", 2, 0, 1, 0, 0, 0, 0, 9);
    expect_at("full_both_end", 5, 0, 0, 0, 0, 0, 0, 9);
    ent = 1'b1;
    ext = 1'b1;
    tick(1);
    ent = 1'b0;
    ext = 1'b0;
    tick(4);

    for (int k = 8; k >= 5; k--) begin
      expect_at("drain", 1, 0, 1, 0, 0, 0, 0, k);
      ext = 1'b1;
      tick(1);
      ext = 1'b0;
      tick(4);
    end

    // simultaneous grants at count 5
    expect_at("both_open1", 1, 1, 1, 0, 0, 0, 0, 5);
    expect_at("both_open4", 4, 1, 1, 0, 0, 0, 0, 5);
    expect_at("both_closed", 5, 0, 0, 0, 0, 0, 0, 5);
    ent = 1'b1;
    ext = 1'b1;
    tick(1);
    ent = 1'b0;
    ext = 1'b0;
    tick(4);

    // asynchronous reset in the 2nd open cycle
    expect_at("rst_open1", 1, 1, 0, 0, 0, 0, 0, 6);
    ent = 1'b1;
    tick(1);
    ent = 1'b0;
    tick(1);
    clr = 1'b0;
    expect_at("async_rst", 0, 0, 0, 0, 0, 0, 1, 0);

    // sensor held high across reset release is one edge
    ent = 1'b1;
    tick(2);
    expect_at("held_in_rst", 0, 0, 0, 0, 0, 0, 1, 0);
    clr = 1'b1;
    expect_at("held_edge", 1, 1, 0, 0, 0, 0, 0, 1);
    expect_at("held_no_retrig", 5, 0, 0, 0, 0, 0, 0, 1);
    tick(6);
    ent = 1'b0;
    tick(2);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick(1);
    while (sb_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", sb_q[0].tag, sb_q[0].cyc);
      sb_q.delete(0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
